// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the down-counting timer.
// Pure declarations: no logic, no latency, no flow control.
// Imported by down_counter_timer and anything that decodes its state.
package down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable, pausable down-counting timer with optional auto-reload and a one-cycle done pulse.
// Latency: count shows N the cycle after the load edge; done is high the cycle after edge E0+N.
// Backpressure: load_ready is low for the whole run; pause stretches the run one cycle per paused cycle.
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] reload;

    assign load_ready = (state == IDLE);
    assign busy       = (state == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        count  <= load_value;
                        reload <= load_value;
                        if (load_value != '0) begin
                            state <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        count <= '0;
                        state <= IDLE;
                    end else if (!pause) begin
                        if (count == CNT_ONE) begin
                            done <= 1'b1;
                            if (auto_reload) begin
                                count <= reload;
                            end else begin
                                count <= '0;
                                state <= IDLE;
                            end
                        end else if (count == '0) begin
                            // Unreachable by construction; never decrement through zero.
                            state <= IDLE;
                        end else begin
                            count <= count - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Loadable, pausable down-counting timer: the counting-down counterpart to the team's free-running 4-bit up counter. It accepts a start value over a valid/ready load port, decrements once per enabled cycle, and pulses `done` when it reaches terminal count. It optionally auto-reloads for periodic ticks. It sits beside the up counter as the interval and timeout generator for control logic.

## Interface
Parameters:
- `WIDTH`, 4: counter and load value width in bits.

Ports:
- `clk`, input, 1: sole clock. All state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `load_valid`, input, 1: a start value is offered on `load_value`.
- `load_ready`, output, 1: the block can accept a load.
- `load_value`, input, WIDTH: start value N.
- `auto_reload`, input, 1: at terminal count, restart from the stored N instead of stopping.
- `pause`, input, 1: hold `count` while running.
- `abort`, input, 1: stop immediately and return to idle.
- `count`, output, WIDTH: current counter value.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle terminal-count pulse.

## Operation
- **States**
  - IDLE: `load_ready`=1, `busy`=0.
  - RUN: `load_ready`=0, `busy`=1.
- **Reset** (`reset_n`=0, any time, including mid-run)
  - State goes to IDLE.
  - `count`=0, `done`=0, `busy`=0, `load_ready`=1, stored reload value=0.
  - Takes effect immediately, with no clock needed.
  - Any run in progress is lost and no `done` is issued.
- **Load handshake**
  - A load is accepted on a rising edge where `load_valid` and `load_ready` are both 1.
  - On acceptance, `count` and the reload register are set to `load_value`.
  - If N≠0, the next state is RUN.
  - If N=0, `done`=1 for the following cycle and the state stays IDLE.
- **RUN, per-edge priority** (highest first)
  - `abort`=1: `count`=0, state goes to IDLE, no `done`.
  - `pause`=1: `count` is held and `done`=0.
  - Otherwise, `count` decrements by 1.
- **Terminal edge** (a decrement while `count`=1)
  - `done`=1 for exactly one cycle.
  - With `auto_reload`=1 sampled at that edge, `count` is set to the reload value and the state stays RUN. `count` never shows 0 in this case.
  - With `auto_reload`=0, `count` goes to 0 and the state goes to IDLE.
- **Arithmetic**
  - Unsigned, WIDTH bits.
  - `count` never decrements from 0: no underflow and no wrap to all-ones.
  - N = 2^WIDTH−1 is legal.
- **Ignored inputs**
  - `load_valid` in RUN has no effect, because `load_ready`=0.
  - `auto_reload` is sampled only at the terminal edge. Changing it mid-run is legal.
  - `pause` and `abort` in IDLE have no effect.

## Timing
- All outputs are registered. `load_ready` and `busy` are decoded directly from the state register.
- **Latency:** a load of N accepted at edge E0 with no pauses gives `count`=N after E0. `count` is N−k after E0+k. `done` is high after E0+N for one cycle.
- **Auto-reload period:** exactly N cycles between `done` pulses when unpaused.
- Each paused cycle extends the run by one cycle.
- A `done` pulse is never stretched by `pause`.
- **Back-to-back loads:** `load_ready` rises in the cycle after a non-reload terminal edge, so the earliest next load is the edge after `done` is asserted.
- `abort` and a terminal edge on the same edge: `abort` wins, with no `done` and `count`=0.

## Structure
- Shared package `down_counter_pkg`:
  - `state_t` enum {IDLE, RUN}.
  - `DEFAULT_WIDTH`=4.
- Single module. No sub-module is natural, since the datapath is one register, one decrementer and one reload register.

## Test plan
- Reset low, then high at 20 ns. Load N=5 with `auto_reload`=0. Required: `count` 5,4,3,2,1,0 on successive edges; `done` high for one cycle coincident with `count`=0; `busy`=0 and `load_ready`=1 the cycle after.
- Load N=3 with `auto_reload`=1. Required: `count` sequence 3,2,1,3,2,1,…; `done` every 3 cycles; `busy` stays 1.
- Load N=4 and hold `pause` for 2 cycles at `count`=2. Required: `count` held at 2 for 2 cycles; `done` arrives 6 cycles after the load edge.
- Load N=0. Required: one `done` pulse the next cycle; `count`=0; `busy` never rises.
- Pulse `abort` at `count`=2. Required: `count`=0 and IDLE next cycle, no `done`. Then assert `reset_n`=0 asynchronously mid-run of N=15: `count`=0 immediately, without a clock edge.
- Drive `load_valid`=1 with `load_value`=9 during a run of N=6. Required: ignored, with `count` continuing 6→0. Then load N=15: full 15-cycle run, no wrap past 0.
